// File: rtl/pio_in_pkg.sv
// pio_in_pkg: shared constants for the pio_in_edge input port.
//   ADDR_*  : Avalon-MM register addresses (2-bit word address).
//   EDGE_*  : values of the EDGE_TYPE parameter selecting the capture polarity.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// pio_in_debounce: single-bit counter debouncer.
//   clk, reset : system clock, async active-high reset
//   i_d        : synchronised input bit
//   o_q        : debounced bit; follows i_d only after it has differed
//                for DEBOUNCE_CYCLES consecutive cycles
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;

    // Terminal compare at DEBOUNCE_CYCLES-1 so that o_q flips on exactly the
    // DEBOUNCE_CYCLES-th clock after i_d first differs from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (i_d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_q   <= i_d;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pio_in_edge.sv
// pio_in_edge: Avalon-MM input port with synchroniser, optional debounce,
// per-bit edge capture and a masked level interrupt.
//   clk, reset      : system clock, async active-high reset
//   address[1:0]    : 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (W1C)
//   chipselect      : slave select; write_n : active-low write strobe
//   writedata[31:0] : write data, bits above WIDTH ignored
//   in_port         : asynchronous pin inputs
//   readdata[31:0]  : registered, zero-extended read data
//   irq             : registered OR of EDGECAP & IRQMASK
// Build option: define PIO_IN_DEBOUNCE_EN to insert one pio_in_debounce per
// bit between the synchroniser and the edge logic.
module pio_in_edge
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] r_cond_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [PW-1:0]    r_prime_cnt;
    logic             w_primed;
    logic             w_wr;
    logic [31:0]      w_rd;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic             w_unused_wdata;

    // Upper writedata bits are don't-care when WIDTH < 32.
    assign w_unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_sync[g]),
            .o_q   (w_cond[g])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign w_cond = w_sync;
`endif

    // Edge detection stays off until the synchroniser has filled and cond_d
    // has caught up, so pins already high at reset release are not captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_prime_cnt <= '0;
        else if (!w_primed) r_prime_cnt <= r_prime_cnt + 1'b1;
    end

    assign w_primed = (r_prime_cnt == PW'(PRIME_CYCLES));

    always_comb begin
        w_rise = w_cond & ~r_cond_d;
        w_fall = ~w_cond & r_cond_d;
        case (EDGE_TYPE)
            EDGE_RISE: w_edge = w_rise;
            EDGE_FALL: w_edge = w_fall;
            default:   w_edge = w_rise | w_fall;
        endcase
        if (!w_primed) w_edge = '0;
    end

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:    w_rd[WIDTH-1:0] = w_cond;
            ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_edgecap;
            default:      w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond_d   <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_cond_d <= w_cond;
            if (w_wr && address == ADDR_IRQMASK)
                r_irqmask <= writedata[WIDTH-1:0];
            // A new edge in the same cycle as its W1C keeps the flag set.
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            r_irq      <= |(r_edgecap & r_irqmask);
            r_readdata <= chipselect ? w_rd : 32'd0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_pio_in_edge.sv
module tb_pio_in_edge;
    import pio_in_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    logic [1:0]  b_address;
    logic        b_chipselect;
    logic        b_write_n;
    logic [31:0] b_writedata;
    logic [31:0] b_in_port;
    logic [31:0] b_readdata;
    logic        b_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_edge #(
        .WIDTH(8), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    pio_in_edge #(
        .WIDTH(32), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
    ) dut32 (
        .clk(clk), .reset(reset), .address(b_address), .chipselect(b_chipselect),
        .write_n(b_write_n), .writedata(b_writedata), .in_port(b_in_port),
        .readdata(b_readdata), .irq(b_irq)
    );

    typedef struct {
        logic [7:0] mask;
        logic [7:0] pin;
        logic [7:0] exp_data;
        logic [7:0] exp_cap;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
        if (sel) begin
            b_address = a; b_writedata = d; b_chipselect = 1'b1; b_write_n = 1'b0;
        end else begin
            address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        end
        tick();
        if (sel) begin b_chipselect = 1'b0; b_write_n = 1'b1; end
        else     begin chipselect = 1'b0; write_n = 1'b1; end
    endtask

    task automatic bus_rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
        if (sel) begin b_address = a; b_chipselect = 1'b1; b_write_n = 1'b1; end
        else     begin address = a; chipselect = 1'b1; write_n = 1'b1; end
        tick();
        d = sel ? b_readdata : readdata;
        if (sel) b_chipselect = 1'b0;
        else     chipselect = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds a continuous DATA read and checks cond flips on exactly the 18th
    // clock after the pin changes (2 sync stages + 16 debounce cycles); the
    // registered read shows it one clock later.
    task automatic chk_db_latency(input string name);
        address = ADDR_DATA; chipselect = 1'b1; write_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) chk({name, "_before"}, readdata, 32'h0);
            if (k == 19) chk({name, "_after"},  readdata, 32'h1);
        end
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] d;

        vecs[0] = '{mask: 8'h01, pin: 8'hA5, exp_data: 8'hA5, exp_cap: 8'hA5, exp_irq: 1'b1};
        vecs[1] = '{mask: 8'h01, pin: 8'h5A, exp_data: 8'h5A, exp_cap: 8'h5A, exp_irq: 1'b0};
        vecs[2] = '{mask: 8'h80, pin: 8'hFF, exp_data: 8'hFF, exp_cap: 8'hA5, exp_irq: 1'b1};
        vecs[3] = '{mask: 8'hFF, pin: 8'h0F, exp_data: 8'h0F, exp_cap: 8'h00, exp_irq: 1'b0};
        vecs[4] = '{mask: 8'h10, pin: 8'h3C, exp_data: 8'h3C, exp_cap: 8'h30, exp_irq: 1'b1};
        vecs[5] = '{mask: 8'hFF, pin: 8'h00, exp_data: 8'h00, exp_cap: 8'h00, exp_irq: 1'b0};

        reset = 1'b1;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        b_address = '0; b_chipselect = 1'b0; b_write_n = 1'b1; b_writedata = '0;
        b_in_port = '0;

`ifdef PIO_IN_DEBOUNCE_EN
        in_port = 8'h00;
        wait_cycles(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        wait_cycles(10);

        // Glitch shorter than the debounce window.
        in_port = 8'h01;
        wait_cycles(10);
        in_port = 8'h00;
        wait_cycles(30);
        bus_rd(1'b0, ADDR_DATA, d);    chk("db_short_data", d, 32'h0);
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("db_short_cap", d, 32'h0);

        // Long pulse: exact debounce latency, then the rise is captured.
        in_port = 8'h01;
        chk_db_latency("db_long");
        wait_cycles(1);
        in_port = 8'h00;
        wait_cycles(30);
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("db_long_cap", d, 32'h1);
        bus_rd(1'b0, ADDR_DATA, d);    chk("db_long_fall_data", d, 32'h0);
        bus_wr(1'b0, ADDR_EDGECAP, 32'hFF);

        // Reset in the middle of a debounce count.
        bus_wr(1'b0, ADDR_IRQMASK, 32'hFF);
        in_port = 8'h01;
        wait_cycles(10);
        address = ADDR_IRQMASK; chipselect = 1'b1;
        reset = 1'b1;
        #2;
        chk("db_midrst_readdata", readdata, 32'h0);
        chk("db_midrst_irq", {31'h0, irq}, 32'h0);
        wait_cycles(3);
        chipselect = 1'b0;
        reset = 1'b0;
        chk_db_latency("db_restart");
`else
        in_port = 8'hFF;
        wait_cycles(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_readdata32", b_readdata, 32'h0);
        reset = 1'b0;
        wait_cycles(10);

        // Pins high through reset: no spurious capture.
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("prime_cap", d, 32'h0);
        bus_rd(1'b0, ADDR_DATA, d);    chk("prime_data", d, 32'hFF);
        tick();
        chk("cs_low_readdata", readdata, 32'h0);
        bus_rd(1'b0, ADDR_IRQMASK, d); chk("mask_reset", d, 32'h0);

        // Writes to DATA and reserved are ignored; reserved reads 0.
        bus_wr(1'b0, ADDR_DATA, 32'h0);
        bus_wr(1'b0, ADDR_RSVD, 32'hFFFF_FFFF);
        bus_rd(1'b0, ADDR_DATA, d);    chk("data_ro", d, 32'hFF);
        bus_rd(1'b0, ADDR_RSVD, d);    chk("rsvd_read", d, 32'h0);
        bus_rd(1'b0, ADDR_IRQMASK, d); chk("rsvd_no_alias", d, 32'h0);

        // Exact capture and irq latency on bit 0.
        in_port = 8'h00;
        wait_cycles(5);
        bus_wr(1'b0, ADDR_IRQMASK, 32'h01);
        address = ADDR_EDGECAP; chipselect = 1'b1; write_n = 1'b1;
        tick();
        in_port = 8'h01;
        wait_cycles(3);
        chk("lat_cap_e3", readdata, 32'h0);
        chk("lat_irq_e3", {31'h0, irq}, 32'h0);
        tick();
        chk("lat_cap_e4", readdata, 32'h1);
        chk("lat_irq_e4", {31'h0, irq}, 32'h1);
        write_n = 1'b0; writedata = 32'h01;
        tick();
        chk("w1c_irq_same", {31'h0, irq}, 32'h1);
        chipselect = 1'b0; write_n = 1'b1;
        tick();
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

        // W1C colliding with a fresh rise on bit 3: the set wins.
        in_port = 8'h09;
        wait_cycles(5);
        in_port = 8'h01;
        wait_cycles(5);
        in_port = 8'h09;
        wait_cycles(2);
        bus_wr(1'b0, ADDR_EDGECAP, 32'h08);
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("collide_cap", d, 32'h08);
        bus_wr(1'b0, ADDR_EDGECAP, 32'h08);
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("plain_w1c", d, 32'h0);

        // Table-driven pin patterns (rising capture only).
        in_port = 8'h00;
        wait_cycles(5);
        bus_wr(1'b0, ADDR_EDGECAP, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            bus_wr(1'b0, ADDR_IRQMASK, {24'h0, vecs[i].mask});
            bus_rd(1'b0, ADDR_IRQMASK, d);
            chk($sformatf("vec%0d_mask", i), d, {24'h0, vecs[i].mask});
            in_port = vecs[i].pin;
            wait_cycles(5);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
            bus_rd(1'b0, ADDR_DATA, d);
            chk($sformatf("vec%0d_data", i), d, {24'h0, vecs[i].exp_data});
            bus_rd(1'b0, ADDR_EDGECAP, d);
            chk($sformatf("vec%0d_cap", i), d, {24'h0, vecs[i].exp_cap});
            bus_wr(1'b0, ADDR_EDGECAP, 32'hFF);
            wait_cycles(2);
            chk($sformatf("vec%0d_irq_clr", i), {31'h0, irq}, 32'h0);
        end

        // 32-bit, any-edge instance: bit 31 up then down.
        bus_wr(1'b1, ADDR_IRQMASK, 32'h8000_0000);
        b_in_port = 32'h8000_0000;
        wait_cycles(5);
        chk("w32_irq_up", {31'h0, b_irq}, 32'h1);
        bus_rd(1'b1, ADDR_EDGECAP, d); chk("w32_cap_up", d, 32'h8000_0000);
        bus_rd(1'b1, ADDR_DATA, d);    chk("w32_data_up", d, 32'h8000_0000);
        bus_wr(1'b1, ADDR_EDGECAP, 32'h8000_0000);
        wait_cycles(2);
        bus_rd(1'b1, ADDR_EDGECAP, d); chk("w32_cap_clr", d, 32'h0);
        chk("w32_irq_clr", {31'h0, b_irq}, 32'h0);
        b_in_port = 32'h0;
        wait_cycles(5);
        bus_rd(1'b1, ADDR_EDGECAP, d); chk("w32_cap_down", d, 32'h8000_0000);
        bus_rd(1'b1, ADDR_DATA, d);    chk("w32_data_down", d, 32'h0);

        // Mid-operation reset with pending captures and irq asserted.
        bus_wr(1'b0, ADDR_IRQMASK, 32'hFF);
        in_port = 8'hFF;
        wait_cycles(5);
        chk("midrst_irq_pre", {31'h0, irq}, 32'h1);
        address = ADDR_EDGECAP; chipselect = 1'b1;
        reset = 1'b1;
        #2;
        chk("midrst_readdata", readdata, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        wait_cycles(3);
        chipselect = 1'b0;
        reset = 1'b0;
        wait_cycles(10);
        bus_rd(1'b0, ADDR_EDGECAP, d); chk("midrst_cap", d, 32'h0);
        bus_rd(1'b0, ADDR_IRQMASK, d); chk("midrst_mask", d, 32'h0);
        bus_rd(1'b0, ADDR_DATA, d);    chk("midrst_data", d, 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
